// File: rtl/prox_filter.sv
// prox_filter: per-channel proximity sensor conditioning.
// Each channel synchronizes its raw comparator input. It then debounces the
// input through a four-state FSM and stretches the near indication so that
// it lasts at least HOLD_CYCLES cycles.
module prox_filter #(
  parameter int NCH         = 3,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [NCH-1:0] raw_in,
  output logic [NCH-1:0] near_out,
  output logic [NCH-1:0] rise_pulse,
  output logic           any_near
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    NEAR    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES);

  // Hold counter decrement that stops at zero.
  function automatic logic [15:0] hold_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  // Release debounce count that stops at the qualification threshold.
  function automatic logic [7:0] deb_inc_sat(input logic [7:0] v);
    return (v < DEB_LAST) ? v + 8'd1 : DEB_LAST;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic        s1;
    logic        s2;
    state_t      state;
    logic [7:0]  deb_cnt;
    logic [15:0] hold_cnt;
    logic        near_r;
    logic        rise_r;

    // Synchronizer, debounce FSM and hold timer; ena=0 freezes everything.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        state    <= IDLE;
        deb_cnt  <= 8'd0;
        hold_cnt <= 16'd0;
        near_r   <= 1'b0;
        rise_r   <= 1'b0;
      end else if (ena) begin
        s1     <= raw_in[c];
        s2     <= s1;
        rise_r <= 1'b0;
        case (state)
          IDLE: begin
            if (s2) begin
              if (DEB_CYCLES == 1) begin
                state    <= NEAR;
                deb_cnt  <= 8'd0;
                hold_cnt <= HOLD_LD;
                near_r   <= 1'b1;
                rise_r   <= 1'b1;
              end else begin
                state   <= ARM;
                deb_cnt <= 8'd1;
              end
            end
          end
          ARM: begin
            if (!s2) begin
              state   <= IDLE;
              deb_cnt <= 8'd0;
            end else if (deb_cnt == DEB_LAST) begin
              state    <= NEAR;
              deb_cnt  <= 8'd0;
              hold_cnt <= HOLD_LD;
              near_r   <= 1'b1;
              rise_r   <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + 8'd1;
            end
          end
          NEAR: begin
            hold_cnt <= hold_dec(hold_cnt);
            if (!s2) begin
              state   <= RELEASE;
              deb_cnt <= 8'd1;
            end
          end
          RELEASE: begin
            hold_cnt <= hold_dec(hold_cnt);
            if (s2) begin
              // Object came back before release qualified: resume NEAR
              // without restarting the hold window or strobing.
              state   <= NEAR;
              deb_cnt <= 8'd0;
            end else if (deb_cnt >= DEB_LAST && hold_cnt == 16'd0) begin
              state   <= IDLE;
              deb_cnt <= 8'd0;
              near_r  <= 1'b0;
            end else begin
              deb_cnt <= deb_inc_sat(deb_cnt);
            end
          end
          default: begin
            state   <= IDLE;
            deb_cnt <= 8'd0;
            near_r  <= 1'b0;
          end
        endcase
      end else begin
        rise_r <= 1'b0;
      end
    end

    assign near_out[c]   = near_r;
    assign rise_pulse[c] = rise_r;
  end

  assign any_near = |near_out;

endmodule

// File: tb/tb_prox_filter.sv
// Directed bench for prox_filter with DEB_CYCLES=4, HOLD_CYCLES=8, NCH=3.
module tb_prox_filter;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] raw_in;
  logic [2:0] near_out;
  logic [2:0] rise_pulse;
  logic       any_near;

  int n_cmp;
  int n_bad;

  prox_filter #(
    .NCH(3),
    .DEB_CYCLES(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .raw_in(raw_in),
    .near_out(near_out),
    .rise_pulse(rise_pulse),
    .any_near(any_near)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] near;
    logic [2:0] rise;
    logic       any;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Step until near_out[ch] is set; n is edges taken, -1 if budget expires.
  task automatic wait_near(input int ch, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (near_out[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int hi;
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    ena    = 1'b1;
    raw_in = 3'b111;

    // Reset with all inputs active, then ch0 qualifies and ch1 glitches 3 cycles.
    tbl[0] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0};
    tbl[1] = '{1'b1, 3'b111, 3'b000, 3'b000, 1'b0};
    tbl[2] = '{1'b0, 3'b011, 3'b000, 3'b000, 1'b0};
    tbl[3] = '{1'b0, 3'b011, 3'b000, 3'b000, 1'b0};
    tbl[4] = '{1'b0, 3'b011, 3'b000, 3'b000, 1'b0};
    tbl[5] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0};
    tbl[6] = '{1'b0, 3'b001, 3'b000, 3'b000, 1'b0};
    tbl[7] = '{1'b0, 3'b001, 3'b001, 3'b001, 1'b1};
    tbl[8] = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1};
    tbl[9] = '{1'b0, 3'b001, 3'b001, 3'b000, 1'b1};

    for (int i = 0; i < 10; i++) begin
      rst    = tbl[i].rst;
      raw_in = tbl[i].raw;
      step();
      chk($sformatf("tbl%0d_near", i), 32'(near_out), 32'(tbl[i].near));
      chk($sformatf("tbl%0d_rise", i), 32'(rise_pulse), 32'(tbl[i].rise));
      chk($sformatf("tbl%0d_any", i), 32'(any_near), 32'(tbl[i].any));
    end

    // Hold stretch on ch2: near lasts hold (8) plus the final release check.
    rst    = 1'b1;
    raw_in = 3'b000;
    step();
    chk("rst_clears_near", 32'(near_out), 32'd0);
    rst    = 1'b0;
    raw_in = 3'b100;
    wait_near(2, 20, n);
    chk("ch2_latency", 32'(n), 32'd6);
    chk("ch2_rise", 32'(rise_pulse), 32'b100);
    raw_in = 3'b000;
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) chk("ch2_rise_once", 32'(rise_pulse), 32'd0);
      if (!near_out[2]) break;
      hi++;
    end
    chk("ch2_hold_len", 32'(hi), 32'd9);
    chk("ch2_any_low", 32'(any_near), 32'd0);

    // Simultaneous rise on ch0/ch1, then ch1 alone released.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    raw_in = 3'b011;
    wait_near(0, 20, n);
    chk("dual_latency", 32'(n), 32'd6);
    chk("dual_near", 32'(near_out), 32'b011);
    chk("dual_rise", 32'(rise_pulse), 32'b011);
    raw_in = 3'b001;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("ch0_kept%0d", i), 32'(near_out[0]), 32'd1);
    end
    chk("ch1_released", 32'(near_out), 32'b001);
    chk("dual_any", 32'(any_near), 32'd1);

    // ena=0 for 10 cycles while ch0 is in ARM delays assertion by 10.
    rst = 1'b1;
    raw_in = 3'b000;
    step();
    rst    = 1'b0;
    raw_in = 3'b001;
    for (int i = 0; i < 3; i++) step();
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("frozen_near%0d", i), 32'(near_out), 32'd0);
    end
    ena = 1'b1;
    wait_near(0, 20, n);
    chk("ena_delay", 32'(n), 32'd3);
    chk("ena_rise", 32'(rise_pulse), 32'b001);

    // ena=0 while NEAR holds near_out and kills the strobe.
    ena = 1'b0;
    step();
    chk("frz_near_hold", 32'(near_out), 32'b001);
    chk("frz_rise_zero", 32'(rise_pulse), 32'd0);
    step();
    chk("frz_near_hold2", 32'(near_out), 32'b001);
    ena = 1'b1;

    // Reset pulse in NEAR (reset wins over ena=0), then full requalification.
    ena = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_in_near", 32'(near_out), 32'd0);
    chk("rst_any", 32'(any_near), 32'd0);
    rst = 1'b0;
    ena = 1'b1;
    wait_near(0, 20, n);
    chk("requal_latency", 32'(n), 32'd6);
    chk("requal_rise", 32'(rise_pulse), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
